// File: rtl/hci_package.sv
// Shared definitions for the HCI core protocol monitor.
// The package holds the rule bit indices, the rule count and a fired-rule counter helper.
package hci_package;

    localparam int HCI_MONITOR_N_ERR = 6;

    typedef enum logic [2:0] {
        ERR_RQ3_STABLE    = 3'd0,
        ERR_RQ4_NORETIRE  = 3'd1,
        ERR_RSP3_STABLE   = 3'd2,
        ERR_RSP5_NORETIRE = 3'd3,
        ERR_STALL         = 3'd4,
        ERR_UNDERFLOW     = 3'd5
    } hci_monitor_err_e;

    function automatic logic [2:0] countFired(input logic [HCI_MONITOR_N_ERR-1:0] fired);
        logic [2:0] total;
        total = '0;
        for (int i = 0; i < HCI_MONITOR_N_ERR; i++) begin
            total = total + {2'b00, fired[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/hci_core_protocol_monitor_channel.sv
// Per-channel HCI protocol rule checker: stability, no-retire, stall and underflow detection.
// The stall counter exists only when HCI_MONITOR_STALL_TIMEOUT_EN is defined.
module hci_core_protocol_monitor_channel
    import hci_package::*;
#(
    parameter int unsigned RQ_PW     = 105,
    parameter int unsigned RSP_PW    = 33,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STALL_THR = 256,
    parameter logic [HCI_MONITOR_N_ERR-1:0] WAIVE_MASK = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic                         gnt_i,
    input  logic [RQ_PW-1:0]             rq_payload_i,
    input  logic                         r_valid_i,
    input  logic                         r_ready_i,
    input  logic [RSP_PW-1:0]            rsp_payload_i,
    input  logic                         clear_i,
    output logic [HCI_MONITOR_N_ERR-1:0] err_o,
    output logic [HCI_MONITOR_N_ERR-1:0] err_next_o,
    output logic [CNT_W-1:0]             err_cnt_o,
    output logic [CNT_W-1:0]             outstanding_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                         prevReq_q, prevGnt_q, prevRValid_q, prevRReady_q;
    logic [RQ_PW-1:0]             prevRqPayload_q;
    logic [RSP_PW-1:0]            prevRspPayload_q;
    logic [HCI_MONITOR_N_ERR-1:0] err_q, err_d;
    logic [CNT_W-1:0]             errCnt_q, errCnt_d;
    logic [CNT_W-1:0]             outst_q, outst_d;

    logic                         rqPending, rspPending, grant, retire, stallFire;
    logic [HCI_MONITOR_N_ERR-1:0] rawFire, fire;
    logic [2:0]                   fireCnt;
    logic [CNT_W-1:0]             cntBase;
    logic [CNT_W+2:0]             cntSum;

`ifdef HCI_MONITOR_STALL_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(STALL_THR + 1);
    localparam logic [STALL_W-1:0] STALL_FIRE = STALL_W'(STALL_THR - 1);
    localparam logic [STALL_W-1:0] STALL_SAT  = STALL_W'(STALL_THR);

    logic [STALL_W-1:0] stallCnt_q, stallCnt_d;

    // The counter parks at STALL_THR so one stall episode fires exactly once.
    always_comb begin
        stallCnt_d = '0;
        stallFire  = 1'b0;
        if (req_i && !gnt_i) begin
            stallFire  = (stallCnt_q == STALL_FIRE);
            stallCnt_d = (stallCnt_q == STALL_SAT) ? stallCnt_q : stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end
`else
    assign stallFire = 1'b0;
`endif

    assign rqPending  = prevReq_q & ~prevGnt_q;
    assign rspPending = prevRValid_q & ~prevRReady_q;
    assign grant      = req_i & gnt_i;
    assign retire     = r_valid_i & r_ready_i;

    always_comb begin
        rawFire                    = '0;
        rawFire[ERR_RQ3_STABLE]    = rqPending & (rq_payload_i != prevRqPayload_q);
        rawFire[ERR_RQ4_NORETIRE]  = rqPending & ~req_i;
        rawFire[ERR_RSP3_STABLE]   = rspPending & (rsp_payload_i != prevRspPayload_q);
        rawFire[ERR_RSP5_NORETIRE] = rspPending & ~r_valid_i;
        rawFire[ERR_STALL]         = stallFire;
        rawFire[ERR_UNDERFLOW]     = retire & ~grant & (outst_q == '0);
        fire                       = rawFire & ~WAIVE_MASK;
        fireCnt                    = countFired(fire);
    end

    // Outstanding stays put when a grant and a retire land in the same cycle.
    always_comb begin
        outst_d = outst_q;
        if (grant && !retire) begin
            if (outst_q != CNT_MAX) begin
                outst_d = outst_q + 1'b1;
            end
        end else if (retire && !grant && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // A clear coinciding with a new event keeps that event's flags and count.
    always_comb begin
        err_d    = (clear_i ? '0 : err_q) | fire;
        cntBase  = clear_i ? '0 : errCnt_q;
        cntSum   = {3'b000, cntBase} + {{CNT_W{1'b0}}, fireCnt};
        errCnt_d = (cntSum > {3'b000, CNT_MAX}) ? CNT_MAX : cntSum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prevReq_q        <= 1'b0;
            prevGnt_q        <= 1'b0;
            prevRValid_q     <= 1'b0;
            prevRReady_q     <= 1'b0;
            prevRqPayload_q  <= '0;
            prevRspPayload_q <= '0;
            err_q            <= '0;
            errCnt_q         <= '0;
            outst_q          <= '0;
        end else begin
            prevReq_q        <= req_i;
            prevGnt_q        <= gnt_i;
            prevRValid_q     <= r_valid_i;
            prevRReady_q     <= r_ready_i;
            prevRqPayload_q  <= rq_payload_i;
            prevRspPayload_q <= rsp_payload_i;
            err_q            <= err_d;
            errCnt_q         <= errCnt_d;
            outst_q          <= outst_d;
        end
    end

    assign err_o         = err_q;
    assign err_next_o    = err_d;
    assign err_cnt_o     = errCnt_q;
    assign outstanding_o = outst_q;

endmodule

// File: rtl/hci_core_protocol_monitor.sv
// Passive multi-channel HCI core protocol monitor with a masked, registered interrupt.
// Define HCI_MONITOR_STALL_TIMEOUT_EN to build the per-channel stall detectors (err_o bit 4).
module hci_core_protocol_monitor
    import hci_package::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned RQ_PW     = 105,
    parameter int unsigned RSP_PW    = 33,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STALL_THR = 256,
    parameter logic [HCI_MONITOR_N_ERR-1:0] WAIVE_MASK = 6'b0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [N_CH-1:0]                         req_i,
    input  logic [N_CH-1:0]                         gnt_i,
    input  logic [N_CH-1:0][RQ_PW-1:0]              rq_payload_i,
    input  logic [N_CH-1:0]                         r_valid_i,
    input  logic [N_CH-1:0]                         r_ready_i,
    input  logic [N_CH-1:0][RSP_PW-1:0]             rsp_payload_i,
    input  logic                                    clear_i,
    input  logic [HCI_MONITOR_N_ERR-1:0]            irq_mask_i,
    output logic [N_CH-1:0][HCI_MONITOR_N_ERR-1:0]  err_o,
    output logic [N_CH-1:0][CNT_W-1:0]              err_cnt_o,
    output logic [N_CH-1:0][CNT_W-1:0]              outstanding_o,
    output logic                                    irq_o
);

    logic [N_CH-1:0][HCI_MONITOR_N_ERR-1:0] errNext;
    logic                                   irq_q, irq_d;

    for (genvar c = 0; c < N_CH; c++) begin : gen_ch
        hci_core_protocol_monitor_channel #(
            .RQ_PW      (RQ_PW),
            .RSP_PW     (RSP_PW),
            .CNT_W      (CNT_W),
            .STALL_THR  (STALL_THR),
            .WAIVE_MASK (WAIVE_MASK)
        ) u_channel (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .req_i         (req_i[c]),
            .gnt_i         (gnt_i[c]),
            .rq_payload_i  (rq_payload_i[c]),
            .r_valid_i     (r_valid_i[c]),
            .r_ready_i     (r_ready_i[c]),
            .rsp_payload_i (rsp_payload_i[c]),
            .clear_i       (clear_i),
            .err_o         (err_o[c]),
            .err_next_o    (errNext[c]),
            .err_cnt_o     (err_cnt_o[c]),
            .outstanding_o (outstanding_o[c])
        );
    end

    // Reducing the next-state flags keeps irq_o aligned with err_o.
    always_comb begin
        irq_d = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            irq_d = irq_d | (|(errNext[c] & irq_mask_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_hci_core_protocol_monitor.sv
// Directed, table-driven bench for hci_core_protocol_monitor (default and CNT_W=2/waived instances).
// Stall expectations follow HCI_MONITOR_STALL_TIMEOUT_EN.
module tb_hci_core_protocol_monitor;

    localparam int N_CH   = 4;
    localparam int RQ_PW  = 105;
    localparam int RSP_PW = 33;

    typedef struct {
        int          ch;
        logic        req;
        logic        gnt;
        logic [31:0] add;
        logic        rv;
        logic        rr;
        logic [31:0] rdata;
        logic        clr;
        logic [5:0]  mask;
        logic [5:0]  expErr;
        logic [7:0]  expCnt;
        logic [7:0]  expOut;
        logic        expIrq;
        logic [5:0]  expErr2;
        logic [1:0]  expCnt2;
    } vec_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                          rst_ni;
    logic [N_CH-1:0]               req, gnt, rValid, rReady;
    logic [N_CH-1:0][RQ_PW-1:0]    rqPayload;
    logic [N_CH-1:0][RSP_PW-1:0]   rspPayload;
    logic                          clear;
    logic [5:0]                    irqMask;
    logic [N_CH-1:0][5:0]          err, err2;
    logic [N_CH-1:0][7:0]          errCnt, outst;
    logic [N_CH-1:0][1:0]          errCnt2, outst2;
    logic                          irq, irq2;

    int   checks = 0;
    int   errors = 0;
    logic expStall;
    vec_t vecs[$];

    hci_core_protocol_monitor dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .gnt_i(gnt), .rq_payload_i(rqPayload),
        .r_valid_i(rValid), .r_ready_i(rReady), .rsp_payload_i(rspPayload), .clear_i(clear),
        .irq_mask_i(irqMask), .err_o(err), .err_cnt_o(errCnt), .outstanding_o(outst), .irq_o(irq)
    );

    hci_core_protocol_monitor #(.CNT_W(2), .WAIVE_MASK(6'b000010)) dutSmall (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .gnt_i(gnt), .rq_payload_i(rqPayload),
        .r_valid_i(rValid), .r_ready_i(rReady), .rsp_payload_i(rspPayload), .clear_i(clear),
        .irq_mask_i(irqMask), .err_o(err2), .err_cnt_o(errCnt2), .outstanding_o(outst2), .irq_o(irq2)
    );

    function automatic vec_t mk(input int ch, input logic rq, input logic gn, input logic [31:0] ad,
                                input logic rv, input logic rr, input logic [31:0] rd, input logic cl,
                                input logic [5:0] mk_, input logic [5:0] eErr, input logic [7:0] eCnt,
                                input logic [7:0] eOut, input logic eIrq, input logic [5:0] eErr2,
                                input logic [1:0] eCnt2);
        vec_t v;
        v.ch = ch; v.req = rq; v.gnt = gn; v.add = ad; v.rv = rv; v.rr = rr; v.rdata = rd;
        v.clr = cl; v.mask = mk_; v.expErr = eErr; v.expCnt = eCnt; v.expOut = eOut;
        v.expIrq = eIrq; v.expErr2 = eErr2; v.expCnt2 = eCnt2;
        return v;
    endfunction

    task automatic driveIdle();
        req = '0; gnt = '0; rValid = '0; rReady = '0;
        rqPayload = '0; rspPayload = '0; clear = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        driveIdle();
        req[v.ch]        = v.req;
        gnt[v.ch]        = v.gnt;
        rqPayload[v.ch]  = RQ_PW'(v.add);
        rValid[v.ch]     = v.rv;
        rReady[v.ch]     = v.rr;
        rspPayload[v.ch] = RSP_PW'(v.rdata);
        clear            = v.clr;
        irqMask          = v.mask;
        step();
    endtask

    initial begin
`ifdef HCI_MONITOR_STALL_TIMEOUT_EN
        expStall = 1'b1;
`else
        expStall = 1'b0;
`endif
        //       ch rq gn add      rv rr rdata clr mask    eErr   eCnt eOut eIrq eErr2  eCnt2
        vecs.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0,     0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(0, 1, 0, 32'h104, 0, 0, 0,     0, 6'h3F, 6'h01, 1, 0, 1, 6'h01, 1));
        vecs.push_back(mk(0, 1, 1, 32'h104, 0, 0, 0,     0, 6'h3F, 6'h01, 1, 1, 1, 6'h01, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0,     0, 6'h3F, 6'h01, 1, 1, 1, 6'h01, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 0,     0, 6'h3F, 6'h01, 1, 0, 1, 6'h01, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 1, 0, 32'h200, 0, 0, 0,     0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 0, 0, 32'h200, 0, 0, 0,     0, 6'h3F, 6'h02, 1, 0, 1, 6'h00, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(2, 1, 1, 32'h10,  0, 0, 0,     0, 6'h3F, 6'h00, 0, 1, 0, 6'h00, 0));
        vecs.push_back(mk(2, 1, 1, 32'h14,  0, 0, 0,     0, 6'h3F, 6'h00, 0, 2, 0, 6'h00, 0));
        vecs.push_back(mk(2, 1, 1, 32'h18,  0, 0, 0,     0, 6'h3F, 6'h00, 0, 3, 0, 6'h00, 0));
        vecs.push_back(mk(2, 0, 0, 32'h0,   1, 1, 0,     0, 6'h3F, 6'h00, 0, 2, 0, 6'h00, 0));
        vecs.push_back(mk(2, 0, 0, 32'h0,   1, 1, 0,     0, 6'h3F, 6'h00, 0, 1, 0, 6'h00, 0));
        vecs.push_back(mk(2, 0, 0, 32'h0,   1, 1, 0,     0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(2, 0, 0, 32'h0,   1, 1, 0,     0, 6'h3F, 6'h20, 1, 0, 1, 6'h20, 1));
        vecs.push_back(mk(2, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(3, 0, 0, 32'h0,   1, 0, 32'hAA, 0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(3, 0, 0, 32'h0,   1, 0, 32'hBB, 0, 6'h3F, 6'h04, 1, 0, 1, 6'h04, 1));
        vecs.push_back(mk(3, 0, 0, 32'h0,   0, 0, 32'hBB, 1, 6'h3F, 6'h08, 1, 0, 1, 6'h08, 1));
        vecs.push_back(mk(3, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(0, 1, 0, 32'h1,   1, 0, 32'h1, 0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(0, 0, 0, 32'h2,   0, 0, 32'h2, 0, 6'h3F, 6'h0F, 4, 0, 1, 6'h0D, 3));
        vecs.push_back(mk(0, 1, 0, 32'h1,   1, 0, 32'h1, 0, 6'h3F, 6'h0F, 4, 0, 1, 6'h0D, 3));
        vecs.push_back(mk(0, 0, 0, 32'h2,   0, 0, 32'h2, 0, 6'h3F, 6'h0F, 8, 0, 1, 6'h0D, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 1, 0, 32'h5,   0, 0, 0,     0, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 0, 0, 32'h5,   0, 0, 0,     0, 6'h3D, 6'h02, 1, 0, 0, 6'h00, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0,     1, 6'h3F, 6'h00, 0, 0, 0, 6'h00, 0));

        $display("[TB] reset");
        rst_ni  = 1'b0;
        irqMask = 6'h3F;
        driveIdle();
        repeat (3) step();
        for (int c = 0; c < N_CH; c++) begin
            checkOutput($sformatf("reset_err_ch%0d", c), 32'(err[c]), 32'h0);
            checkOutput($sformatf("reset_cnt_ch%0d", c), 32'(errCnt[c]), 32'h0);
            checkOutput($sformatf("reset_out_ch%0d", c), 32'(outst[c]), 32'h0);
        end
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_irq_small", 32'(irq2), 32'h0);
        rst_ni = 1'b1;
        step();

        $display("[TB] vector table, %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d_err", i), 32'(err[vecs[i].ch]), 32'(vecs[i].expErr));
            checkOutput($sformatf("row%0d_cnt", i), 32'(errCnt[vecs[i].ch]), 32'(vecs[i].expCnt));
            checkOutput($sformatf("row%0d_out", i), 32'(outst[vecs[i].ch]), 32'(vecs[i].expOut));
            checkOutput($sformatf("row%0d_irq", i), 32'(irq), 32'(vecs[i].expIrq));
            checkOutput($sformatf("row%0d_err_small", i), 32'(err2[vecs[i].ch]), 32'(vecs[i].expErr2));
            checkOutput($sformatf("row%0d_cnt_small", i), 32'(errCnt2[vecs[i].ch]), 32'(vecs[i].expCnt2));
            checkOutput($sformatf("row%0d_out_small", i), 32'(outst2[vecs[i].ch]), 32'(vecs[i].expOut));
        end

        $display("[TB] stall on channel 3");
        driveIdle();
        irqMask = 6'h3F;
        for (int k = 1; k <= 255; k++) begin
            req[3] = 1'b1; gnt[3] = 1'b0; rqPayload[3] = RQ_PW'(32'h33);
            step();
        end
        checkOutput("stall_before_thr_flag", 32'(err[3][4]), 32'h0);
        checkOutput("stall_before_thr_cnt", 32'(errCnt[3]), 32'h0);
        step();
        checkOutput("stall_at_thr_flag", 32'(err[3][4]), 32'(expStall));
        checkOutput("stall_at_thr_cnt", 32'(errCnt[3]), 32'(expStall));
        checkOutput("stall_at_thr_irq", 32'(irq), 32'(expStall));
        step();
        checkOutput("stall_held_cnt", 32'(errCnt[3]), 32'(expStall));
        gnt[3] = 1'b1;
        step();
        checkOutput("stall_grant_out", 32'(outst[3]), 32'h1);
        checkOutput("stall_grant_err", 32'(err[3]), {31'h0, expStall} << 4);

        $display("[TB] reset mid-transaction");
        driveIdle();
        req[2] = 1'b1; gnt[2] = 1'b1;
        step();
        step();
        checkOutput("midrst_out_before", 32'(outst[2]), 32'h2);
        driveIdle();
        rst_ni = 1'b0;
        req[0] = 1'b1; rqPayload[0] = RQ_PW'(32'h1);
        step();
        rqPayload[0] = RQ_PW'(32'h2);
        step();
        checkOutput("midrst_out_ch2", 32'(outst[2]), 32'h0);
        checkOutput("midrst_out_ch3", 32'(outst[3]), 32'h0);
        checkOutput("midrst_err_ch3", 32'(err[3]), 32'h0);
        checkOutput("midrst_irq", 32'(irq), 32'h0);
        rst_ni = 1'b1;
        rqPayload[0] = RQ_PW'(32'h3);
        rValid[2] = 1'b1; rReady[2] = 1'b1;
        step();
        checkOutput("first_cycle_no_rq3", 32'(err[0]), 32'h0);
        checkOutput("post_rst_underflow_err", 32'(err[2]), 32'h20);
        checkOutput("post_rst_underflow_cnt", 32'(errCnt[2]), 32'h1);
        checkOutput("post_rst_underflow_out", 32'(outst[2]), 32'h0);
        checkOutput("post_rst_underflow_irq", 32'(irq), 32'h1);
        gnt[0] = 1'b1;
        rValid[2] = 1'b0; rReady[2] = 1'b0;
        step();
        driveIdle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hci_core_protocol_monitor.md
HCI_CORE_PROTOCOL_MONITOR -- requirements
Module: hci_core_protocol_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of monitored HCI core channels.
REQ-002 SHALL have parameter RQ_PW, default 105: packed request payload width (add, wen, data, be, user, ecc, id).
REQ-003 SHALL have parameter RSP_PW, default 33: packed response payload width (r_data, r_user, r_ecc, r_id).
REQ-004 SHALL have parameter CNT_W, default 8: width of violation and outstanding counters.
REQ-005 SHALL have parameter STALL_THR, default 256: number of consecutive ungranted request cycles that flags a stall.
REQ-006 SHALL have parameter WAIVE_MASK, default 6'b0: per-rule waiver, a set bit suppresses that rule on all channels.
REQ-007 clk_i  in  1  sole clock; one clock, reset synchronous active-low.
REQ-008 rst_ni  in  1  synchronous active-low reset.
REQ-009 req_i / gnt_i  in  N_CH  request handshake per channel.
REQ-010 rq_payload_i  in  N_CH x RQ_PW  request payload per channel.
REQ-011 r_valid_i / r_ready_i  in  N_CH  response handshake per channel.
REQ-012 rsp_payload_i  in  N_CH x RSP_PW  response payload per channel.
REQ-013 clear_i  in  1  single-cycle clear of all sticky flags and violation counters.
REQ-014 irq_mask_i  in  6  per-rule interrupt enable.
REQ-015 err_o  out  N_CH x 6  sticky per-channel rule flags.
REQ-016 err_cnt_o  out  N_CH x CNT_W  per-channel saturating violation count.
REQ-017 outstanding_o  out  N_CH x CNT_W  granted-minus-retired transactions.
REQ-018 irq_o  out  1  registered OR of err_o AND irq_mask_i over all channels.

Function
REQ-019 Bit indices: 0 RQ3 stability, 1 RQ4 noretire, 2 RSP3 stability, 3 RSP5 noretire, 4 STALL, 5 UNDERFLOW.
REQ-020 Registered previous-cycle copies SHALL be kept of req, gnt, rq_payload, r_valid, r_ready and rsp_payload.
REQ-021 RQ3 fires in cycle t if req(t-1) & ~gnt(t-1) and rq_payload(t) != rq_payload(t-1).
REQ-022 RQ4 fires if req(t-1) & ~gnt(t-1) & ~req(t).
REQ-023 RSP3 and RSP5 follow REQ-021/022 with r_valid, r_ready and rsp_payload.
REQ-024 Per-channel stall counter increments on req & ~gnt; clears on gnt or ~req; STALL fires on the cycle it reaches STALL_THR-1; it holds without wrapping until cleared.
REQ-025 Outstanding count: +1 on req&gnt, -1 on r_valid&r_ready, unchanged when both occur; it saturates at 2^CNT_W-1.
REQ-026 UNDERFLOW fires on r_valid&r_ready with outstanding = 0 and no same-cycle grant; the count stays 0.
REQ-027 Detection is combinational in cycle t; err_o, err_cnt_o and irq_o SHALL update at edge t+1 (1-cycle latency).
REQ-028 err_cnt_o adds the number of non-waived rules firing that cycle (0..6) and saturates at 2^CNT_W-1.
REQ-029 If clear_i coincides with a firing rule, the new event wins: the flag is set and the counter loads the fired-rule count.
REQ-030 Waived rules SHALL never set flags, count, or raise irq.
REQ-031 The monitor is purely observing: it has no outputs toward the monitored channels.

Reset
REQ-032 On rst_ni=0 at a clk_i edge, all outputs and the internal previous-cycle, stall and outstanding registers SHALL go to 0.
REQ-033 The first cycle after reset SHALL produce no RQ3/RQ4/RSP3/RSP5 events, because previous req/r_valid are 0.
REQ-034 Reset mid-transaction discards outstanding counts; any later responses then flag UNDERFLOW.

Configuration
REQ-035 Macro HCI_MONITOR_STALL_TIMEOUT_EN defined: the stall counters and bit 4 are implemented.
REQ-036 Macro undefined: no stall counters are synthesised, and err_o bit 4 is tied 0.

Structure
REQ-037 hci_package SHALL hold the hci_monitor_err_e bit-index enum and the constant HCI_MONITOR_N_ERR = 6.
REQ-038 Per-channel logic SHALL live in sub-module hci_core_protocol_monitor_channel, instantiated N_CH times; the top holds the irq reduction only.

Verification
REQ-039 Ch0: req=1, gnt=0 for 2 cycles with add changing 0x100->0x104 -> err_o[0][0]=1 one cycle later, err_cnt_o[0]=1, irq_o=1 with mask bit0 set.
REQ-040 Ch1: req=1, gnt=0, then req=0 -> err_o[1][1]=1; with WAIVE_MASK[1]=1 the same stimulus -> flags stay 0.
REQ-041 Ch2: 3 granted requests, then 3 responses, with a 4th response on r_valid=r_ready=1 -> outstanding 3->0, then err_o[2][5]=1.
REQ-042 Ch3: req held ungranted 256 cycles (macro on) -> err_o[3][4]=1 at cycle 256; macro off -> stays 0.
REQ-043 Clear on the same cycle as a new RSP5 event -> err_o[ch][3]=1, other flags 0, err_cnt_o=1.
REQ-044 CNT_W=2 with 5 violations -> err_cnt_o saturates at 3.
